// File: rtl/xc_rf_pkg.sv
// Shared definitions for the GPR-file write-back path: widths, the write-back FSM
// encoding and the even/odd register-pair address helpers.
package xc_rf_pkg;

  localparam int XC_RF_AW = 5;
  localparam int XC_RF_DW = 32;

  typedef enum logic {
    XC_WB_IDLE    = 1'b0,
    XC_WB_PAIR_HI = 1'b1
  } xc_wb_state_e;

  function automatic logic [XC_RF_AW-1:0] pair_lo_addr(input logic [XC_RF_AW-1:0] addr);
    return {addr[XC_RF_AW-1:1], 1'b0};
  endfunction

  function automatic logic [XC_RF_AW-1:0] pair_hi_addr(input logic [XC_RF_AW-1:0] addr);
    return {addr[XC_RF_AW-1:1], 1'b1};
  endfunction

endpackage

// File: rtl/xc_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr,
// wrapping to the lowest set bit below ptr.
module xc_rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic          upper_any_s;
  logic          lower_any_s;
  logic [PW-1:0] upper_idx_s;
  logic [PW-1:0] lower_idx_s;

  // Scan downward so the lowest matching index in each half wins.
  always_comb begin
    upper_any_s = 1'b0;
    lower_any_s = 1'b0;
    upper_idx_s = '0;
    lower_idx_s = '0;
    for (int j = N - 1; j >= 0; j--) begin
      upper_any_s = upper_any_s | (req[j] && (PW'(j) >= ptr));
      upper_idx_s = (req[j] && (PW'(j) >= ptr)) ? PW'(j) : upper_idx_s;
      lower_any_s = lower_any_s | (req[j] && (PW'(j) < ptr));
      lower_idx_s = (req[j] && (PW'(j) < ptr)) ? PW'(j) : lower_idx_s;
    end
  end

  // Requests at or after the pointer take precedence over wrapped ones.
  always_comb begin
    any   = upper_any_s | lower_any_s;
    idx   = upper_any_s ? upper_idx_s : lower_idx_s;
    if (any) begin
      grant = {{(N-1){1'b0}}, 1'b1} << idx;
    end else begin
      grant = '0;
    end
  end

endmodule

// File: rtl/xc_rf_wb_arb.sv
// Write-back arbiter for the single rd port of the GPR file: round-robin between
// result producers, expanding 64-bit pair results into lo/hi write beats.
module xc_rf_wb_arb
  import xc_rf_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int PTRW = 2
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic [NREQ-1:0]                req_valid,
  input  logic [NREQ-1:0]                req_pair,
  input  logic [NREQ*XC_RF_AW-1:0]       req_addr,
  input  logic [NREQ*2*XC_RF_DW-1:0]     req_wdata,
  output logic [NREQ-1:0]                req_ready,
  output logic                           rd_wen,
  output logic [XC_RF_AW-1:0]            rd_addr,
  output logic [XC_RF_DW-1:0]            rd_wdata,
  output logic                           busy
);

  localparam int WW = 2 * XC_RF_DW;

  xc_wb_state_e        state_r;
  xc_wb_state_e        state_nxt_s;
  logic [PTRW-1:0]     rr_ptr_r;
  logic [PTRW-1:0]     rr_ptr_nxt_s;
  logic [NREQ-1:0]     grant_s;
  logic [PTRW-1:0]     win_idx_s;
  logic                win_any_s;
  logic                accept_s;
  logic                win_pair_s;
  logic [XC_RF_AW-1:0] win_addr_s;
  logic [WW-1:0]       win_wdata_s;
  logic [XC_RF_AW-1:0] hi_addr_r;
  logic [XC_RF_DW-1:0] hi_data_r;

  xc_rr_pick #(
    .N  (NREQ),
    .PW (PTRW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_r),
    .grant (grant_s),
    .idx   (win_idx_s),
    .any   (win_any_s)
  );

  // Grants are only offered out of reset and while no hi beat is owed.
  always_comb begin
    accept_s  = 1'b0;
    req_ready = '0;
    if (resetn && (state_r == XC_WB_IDLE) && win_any_s) begin
      accept_s  = 1'b1;
      req_ready = grant_s;
    end else begin
      accept_s  = 1'b0;
      req_ready = '0;
    end
  end

  // One-hot AND-OR mux of the winning request fields.
  always_comb begin
    win_pair_s  = 1'b0;
    win_addr_s  = '0;
    win_wdata_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      win_pair_s  = win_pair_s | (grant_s[i] & req_pair[i]);
      win_addr_s  = win_addr_s | ({XC_RF_AW{grant_s[i]}} & req_addr[i*XC_RF_AW +: XC_RF_AW]);
      win_wdata_s = win_wdata_s | ({WW{grant_s[i]}} & req_wdata[i*WW +: WW]);
    end
  end

  // Pointer moves to the slot after the winner, modulo NREQ.
  always_comb begin
    if (win_idx_s == PTRW'(NREQ - 1)) begin
      rr_ptr_nxt_s = '0;
    end else begin
      rr_ptr_nxt_s = win_idx_s + PTRW'(1);
    end
  end

  // Write-back FSM state register.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r <= XC_WB_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Write-back FSM next state: a pair acceptance owes exactly one hi beat.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      XC_WB_IDLE: begin
        if (accept_s && win_pair_s) begin
          state_nxt_s = XC_WB_PAIR_HI;
        end else begin
          state_nxt_s = XC_WB_IDLE;
        end
      end
      XC_WB_PAIR_HI: state_nxt_s = XC_WB_IDLE;
      default:       state_nxt_s = XC_WB_IDLE;
    endcase
  end

  // Round-robin pointer register.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rr_ptr_r <= '0;
    end else if (accept_s) begin
      rr_ptr_r <= rr_ptr_nxt_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Registered rd port; x0 targets consume the slot but never assert the enable.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rd_wen    <= 1'b0;
      rd_addr   <= '0;
      rd_wdata  <= '0;
      hi_addr_r <= '0;
      hi_data_r <= '0;
    end else if (state_r == XC_WB_PAIR_HI) begin
      rd_wen   <= 1'b1;
      rd_addr  <= hi_addr_r;
      rd_wdata <= hi_data_r;
    end else if (accept_s) begin
      rd_wdata <= win_wdata_s[XC_RF_DW-1:0];
      if (win_pair_s) begin
        rd_addr   <= pair_lo_addr(win_addr_s);
        rd_wen    <= (pair_lo_addr(win_addr_s) != {XC_RF_AW{1'b0}});
        hi_addr_r <= pair_hi_addr(win_addr_s);
        hi_data_r <= win_wdata_s[WW-1:XC_RF_DW];
      end else begin
        rd_addr <= win_addr_s;
        rd_wen  <= (win_addr_s != {XC_RF_AW{1'b0}});
      end
    end else begin
      rd_wen <= 1'b0;
    end
  end

  assign busy = (state_r == XC_WB_PAIR_HI);

endmodule
